upg_loader: RTL and testbench

- UART programming sequencer. It converts the received byte stream from the UART receiver into 32-bit word writes on the upg_* programming port of the instruction memory and the data memory.
- While programming is in progress it holds upg_done_o low, so both memories stay connected to the programmer rather than the CPU.
- On an end-of-load command it raises upg_done_o, which hands both memories back to the CPU.
- It sits between the UART RX core and the two memory blocks, in the upg_clk_i domain.

---
 rtl/upg_pkg.sv | 24 ++
 rtl/upg_word_asm.sv | 31 +++
 rtl/upg_loader.sv | 172 +++++++++++++++++
 tb/tb_upg_loader.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/upg_pkg.sv
// Shared constants and state encoding for the UART programming sequencer.
package upg_pkg;

    localparam logic [7:0] TAG_IMEM = 8'h49;
    localparam logic [7:0] TAG_DMEM = 8'h44;
    localparam logic [7:0] TAG_END  = 8'h45;

    localparam logic SEL_IMEM = 1'b0;
    localparam logic SEL_DMEM = 1'b1;

    typedef enum logic [2:0] {
        S_TAG,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_DONE,
        S_ERR
    } state_t;

    function automatic logic is_seg_tag(input logic [7:0] b);
        return (b == TAG_IMEM) || (b == TAG_DMEM);
    endfunction

endpackage

// File: rtl/upg_word_asm.sv
// Little-endian byte-to-word assembler: the first byte of a word lands in bits [7:0].
module upg_word_asm
    import upg_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [23:0] shreg;
    logic [1:0]  count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            shreg <= '0;
            count <= '0;
        end else if (byte_valid) begin
            shreg <= {byte_data, shreg[23:8]};
            count <= count + 2'd1;
        end
    end

    // The 4th byte is still on the input, so the finished word is formed combinationally.
    assign word_valid = byte_valid && (count == 2'd3);
    assign word       = {byte_data, shreg};

endmodule

// File: rtl/upg_loader.sv
// UART programming sequencer: parses tagged segments from the RX byte stream and
// issues 32-bit word writes to instruction or data memory until an end tag.
module upg_loader
    import upg_pkg::*;
#(
    parameter int ADDR_W      = 14,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rx_valid_i,
    input  logic [7:0]        rx_data_i,
    output logic              upg_wen_o,
    output logic              upg_sel_o,
    output logic [ADDR_W-1:0] upg_adr_o,
    output logic [31:0]       upg_dat_o,
    output logic              upg_done_o,
    output logic              err_o
);

    localparam int IDX_W = ADDR_W + 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [16:0]      MAX_WORDS  = 17'd1 << ADDR_W;
    localparam logic [CNT_W-1:0] IDLE_LIMIT = CNT_W'(TIMEOUT_CYC - 1);

    // rx_valid_i is a one-cycle strobe with no back-pressure: a byte is consumed on
    // every clock where it is high, so every state must take or ignore it that cycle.

    state_t            state, state_nxt;
    logic              sel_q, sel_nxt;
    logic [15:0]       len_q, len_nxt;
    logic [IDX_W-1:0]  idx_q, idx_nxt;
    logic [CNT_W-1:0]  idle_q, idle_nxt;
    logic              wen_q, wen_nxt;
    logic              sel_out_q, sel_out_nxt;
    logic [ADDR_W-1:0] adr_q, adr_nxt;
    logic [31:0]       dat_q, dat_nxt;

    logic        asm_clr;
    logic        asm_valid;
    logic        word_valid;
    logic [31:0] word;
    logic [15:0] len_full;
    logic        last_word;
    logic        in_segment;

    assign asm_valid  = rx_valid_i && (state == S_DATA);
    assign len_full   = {rx_data_i, len_q[7:0]};
    assign last_word  = (17'(idx_q) + 17'd1) == {1'b0, len_q};
    assign in_segment = state inside {S_LEN0, S_LEN1, S_DATA};

    upg_word_asm u_word_asm (
        .clk        (clk_i),
        .rst        (rst_i),
        .clr        (asm_clr),
        .byte_valid (asm_valid),
        .byte_data  (rx_data_i),
        .word_valid (word_valid),
        .word       (word)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= S_TAG;
            sel_q     <= SEL_IMEM;
            len_q     <= '0;
            idx_q     <= '0;
            idle_q    <= '0;
            wen_q     <= 1'b0;
            sel_out_q <= SEL_IMEM;
            adr_q     <= '0;
            dat_q     <= '0;
        end else begin
            state     <= state_nxt;
            sel_q     <= sel_nxt;
            len_q     <= len_nxt;
            idx_q     <= idx_nxt;
            idle_q    <= idle_nxt;
            wen_q     <= wen_nxt;
            sel_out_q <= sel_out_nxt;
            adr_q     <= adr_nxt;
            dat_q     <= dat_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        sel_nxt     = sel_q;
        len_nxt     = len_q;
        idx_nxt     = idx_q;
        idle_nxt    = '0;
        wen_nxt     = 1'b0;
        sel_out_nxt = sel_out_q;
        adr_nxt     = adr_q;
        dat_nxt     = dat_q;
        asm_clr     = 1'b0;

        if (in_segment && !rx_valid_i) begin
            idle_nxt = idle_q + CNT_W'(1);
        end

        // Index advances the cycle after the write; a new tag's clear below takes priority.
        if (wen_q) begin
            idx_nxt = idx_q + IDX_W'(1);
        end

        case (state)
            S_TAG: begin
                if (rx_valid_i) begin
                    if (is_seg_tag(rx_data_i)) begin
                        sel_nxt   = (rx_data_i == TAG_DMEM) ? SEL_DMEM : SEL_IMEM;
                        idx_nxt   = '0;
                        state_nxt = S_LEN0;
                    end else if (rx_data_i == TAG_END) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_ERR;
                    end
                end
            end
            S_LEN0: begin
                if (rx_valid_i) begin
                    len_nxt[7:0] = rx_data_i;
                    state_nxt    = S_LEN1;
                end
            end
            S_LEN1: begin
                if (rx_valid_i) begin
                    len_nxt[15:8] = rx_data_i;
                    if (len_full == 16'd0) begin
                        state_nxt = S_TAG;
                    end else if ({1'b0, len_full} > MAX_WORDS) begin
                        state_nxt = S_ERR;
                    end else begin
                        asm_clr   = 1'b1;
                        state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (word_valid) begin
                    wen_nxt     = 1'b1;
                    dat_nxt     = word;
                    adr_nxt     = idx_q[ADDR_W-1:0];
                    sel_out_nxt = sel_q;
                    if (last_word) begin
                        state_nxt = S_TAG;
                    end
                end
            end
            S_DONE: begin
            end
            S_ERR: begin
            end
            default: begin
                state_nxt = S_ERR;
            end
        endcase

        if (in_segment && !rx_valid_i && (idle_q == IDLE_LIMIT)) begin
            state_nxt = S_ERR;
        end
    end

    assign upg_wen_o  = wen_q;
    assign upg_sel_o  = sel_out_q;
    assign upg_adr_o  = adr_q;
    assign upg_dat_o  = dat_q;
    assign upg_done_o = (state == S_DONE);
    assign err_o      = (state == S_ERR);

endmodule

// File: tb/tb_upg_loader.sv
// Bench for upg_loader: tag table, directed multi-cycle sequences, and random streams
// checked against a segment-parsing reference model.
module tb_upg_loader;

    localparam int AW = 14;
    localparam int TO = 100;
    localparam int MAXW = 16384;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          wen;
    logic          sel;
    logic [AW-1:0] adr;
    logic [31:0]   dat;
    logic          done;
    logic          err;

    int vectors = 0;
    int miscompares = 0;

    logic [46:0] exp_q[$];
    logic [46:0] obs_q[$];
    logic [7:0]  stream_q[$];
    logic [7:0]  tx_q[$];
    logic        exp_done;
    logic        exp_err;
    int          obs_base = 0;
    int          overlap_cnt = 0;
    logic        prev_wen = 1'b0;

    typedef struct {
        logic [7:0] b0;
        logic       d1;
        logic       e1;
        logic [7:0] b1;
        logic       d2;
        logic       e2;
    } tag_vec_t;

    tag_vec_t tv[7];

    upg_loader #(.ADDR_W(AW), .TIMEOUT_CYC(TO)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .rx_valid_i (rx_valid),
        .rx_data_i  (rx_data),
        .upg_wen_o  (wen),
        .upg_sel_o  (sel),
        .upg_adr_o  (adr),
        .upg_dat_o  (dat),
        .upg_done_o (done),
        .err_o      (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wen) begin
            if (prev_wen) overlap_cnt++;
            obs_q.push_back({sel, adr, dat});
        end
        prev_wen = wen;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rx_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        obs_base = obs_q.size();
        exp_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic drive_stream(input int max_gap);
        tx_q = stream_q;
        while (tx_q.size() > 0) begin
            send_byte(tx_q.pop_front());
            repeat ($urandom_range(0, max_gap)) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    // Walks the byte stream segment by segment and lists every write it implies.
    task automatic model_stream();
        int i;
        int n;
        logic [7:0] t;
        logic s;
        exp_q.delete();
        exp_done = 1'b0;
        exp_err = 1'b0;
        i = 0;
        while (i < stream_q.size()) begin
            t = stream_q[i];
            i++;
            if (t == 8'h45) begin
                exp_done = 1'b1;
                break;
            end
            if (t != 8'h49 && t != 8'h44) begin
                exp_err = 1'b1;
                break;
            end
            s = (t == 8'h44);
            n = int'(stream_q[i]) + 256 * int'(stream_q[i+1]);
            i += 2;
            if (n > MAXW) begin
                exp_err = 1'b1;
                break;
            end
            for (int w = 0; w < n; w++) begin
                exp_q.push_back({s, 14'(w), stream_q[i+3], stream_q[i+2], stream_q[i+1], stream_q[i]});
                i += 4;
            end
        end
    endtask

    task automatic check_writes(input string name);
        int got;
        int m;
        got = obs_q.size() - obs_base;
        chk({name, "_wcount"}, got, exp_q.size());
        m = (got < exp_q.size()) ? got : exp_q.size();
        for (int i = 0; i < m; i++) begin
            chk({name, "_write"}, obs_q[obs_base + i], exp_q[i]);
        end
    endtask

    task automatic check_end(input string name, input logic d, input logic e);
        repeat (4) @(posedge clk);
        #1;
        check_writes(name);
        chk({name, "_done"}, done, d);
        chk({name, "_err"}, err, e);
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_wen"}, wen, 0);
        chk({name, "_sel"}, sel, 0);
        chk({name, "_adr"}, adr, 0);
        chk({name, "_dat"}, dat, 0);
        chk({name, "_done"}, done, 0);
        chk({name, "_err"}, err, 0);
    endtask

    initial begin
        logic [7:0] b;
        int nseg;

        tv[0] = '{8'h45, 1'b1, 1'b0, 8'h5A, 1'b1, 1'b0};
        tv[1] = '{8'h5A, 1'b0, 1'b1, 8'h45, 1'b0, 1'b1};
        tv[2] = '{8'h00, 1'b0, 1'b1, 8'h49, 1'b0, 1'b1};
        tv[3] = '{8'hFF, 1'b0, 1'b1, 8'h45, 1'b0, 1'b1};
        tv[4] = '{8'h49, 1'b0, 1'b0, 8'h45, 1'b0, 1'b0};
        tv[5] = '{8'h44, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        tv[6] = '{8'h45, 1'b1, 1'b0, 8'h45, 1'b1, 1'b0};

        do_reset();
        check_reset_outputs("reset");

        for (int k = 0; k < 7; k++) begin
            do_reset();
            send_byte(tv[k].b0);
            chk("tag_done1", done, tv[k].d1);
            chk("tag_err1", err, tv[k].e1);
            send_byte(tv[k].b1);
            chk("tag_done2", done, tv[k].d2);
            chk("tag_err2", err, tv[k].e2);
            repeat (2) @(posedge clk);
            #1;
            chk("tag_wcount", obs_q.size() - obs_base, 0);
        end

        do_reset();
        stream_q = '{8'h44, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                     8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h45};
        exp_q = '{{1'b1, 14'd0, 32'h44332211}, {1'b1, 14'd1, 32'hDDCCBBAA}};
        drive_stream(0);
        check_end("dmem2", 1'b1, 1'b0);

        do_reset();
        stream_q = '{8'h49, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE,
                     8'h44, 8'h00, 8'h00, 8'h45};
        exp_q = '{{1'b0, 14'd0, 32'hDEADBEEF}};
        drive_stream(2);
        check_end("imem1_d0", 1'b1, 1'b0);

        do_reset();
        stream_q = '{8'h44, 8'h01, 8'h00, 8'h12, 8'h34};
        drive_stream(0);
        repeat (TO - 2) @(posedge clk);
        #1;
        chk("timeout_early_err", err, 0);
        repeat (4) @(posedge clk);
        #1;
        chk("timeout_err", err, 1);
        check_end("timeout", 1'b0, 1'b1);

        do_reset();
        stream_q = '{8'h44, 8'h01, 8'h40, 8'h45};
        drive_stream(0);
        check_end("len4001", 1'b0, 1'b1);

        do_reset();
        stream_q = '{8'h44, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        drive_stream(0);
        rx_valid = 1'b1;
        rx_data = 8'h07;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rx_valid = 1'b0;
        check_reset_outputs("midreset");
        obs_base = obs_q.size();
        stream_q = '{8'h49, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h45};
        exp_q = '{{1'b0, 14'd0, 32'h04030201}};
        drive_stream(0);
        check_end("after_reset", 1'b1, 1'b0);

        for (int r = 0; r < 15; r++) begin
            do_reset();
            stream_q.delete();
            nseg = $urandom_range(1, 3);
            for (int s = 0; s < nseg; s++) begin
                int n;
                n = $urandom_range(0, 4);
                stream_q.push_back(($urandom_range(0, 1) == 1) ? 8'h44 : 8'h49);
                stream_q.push_back(8'(n));
                stream_q.push_back(8'h00);
                for (int j = 0; j < 4 * n; j++) stream_q.push_back(8'($urandom));
            end
            if ($urandom_range(0, 5) == 0) begin
                b = 8'h45;
                while (b == 8'h44 || b == 8'h45 || b == 8'h49) b = 8'($urandom);
                stream_q.push_back(b);
            end else begin
                stream_q.push_back(8'h45);
            end
            repeat ($urandom_range(0, 3)) stream_q.push_back(8'($urandom));
            model_stream();
            drive_stream(3);
            check_end("random", exp_done, exp_err);
        end

        do_reset();
        stream_q.delete();
        stream_q.push_back(8'h44);
        stream_q.push_back(8'h00);
        stream_q.push_back(8'h40);
        for (int j = 0; j < 4 * MAXW; j++) stream_q.push_back(8'($urandom));
        stream_q.push_back(8'h45);
        model_stream();
        drive_stream(0);
        check_end("len4000", 1'b1, 1'b0);
        chk("len4000_last_adr", adr, 14'h3FFF);

        chk("wen_no_overlap", overlap_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
